spi_host: RTL and testbench
===========================

# spi_host

Parametrised SPI host for the Z80 I/O bus, the successor to the single-slave microSD interface. It gives software up to six chip selects, a programmable SCK divider, and a selectable SPI mode 0/3 idle level. A readable status port exposes busy and overrun flags. It sits on the same decoded 8-bit port space as the other peripherals; its `q` output is muxed into the CPU data bus when `qe` is high.

## Interface

Parameters:
- `CS_COUNT`, 2: number of chip-select outputs (1..6).
- `PORT_CTRL`, 8'h1F: control (write) / status (read) port.
- `PORT_DATA`, 8'h3F: data port.
- `PORT_DIV`, 8'h5F: divider port (write only).
- `DIV_RESET`, 8'd3: divider value after reset.

Ports:
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `iorq` in 1: I/O request, active-low.
- `rd` in 1: read strobe, active-low.
- `wr` in 1: write strobe, active-low.
- `a` in 8: low address byte.
- `d` in 8: CPU write data.
- `q` out 8: read data; 8'hFF when not selected.
- `qe` out 1: high while a read of `PORT_CTRL` or `PORT_DATA` is decoded.
- `cs` out CS_COUNT: chip selects, active-low.
- `ck` out 1: SCK.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation

- Access decode: `acc = !iorq && a==PORT_x && (!rd || !wr)`. Each access is registered. The action fires once, on the first clock where `acc` is high and the previous-cycle `acc` was low. Long Z80 I/O cycles therefore trigger exactly once.
- `PORT_CTRL` write:
  - `cs <= d[CS_COUNT-1:0]`.
  - `mode <= d[7]`: 0 = mode 0, idle SCK low; 1 = mode 3, idle SCK high.
  - Applied immediately, even while busy.
- `PORT_CTRL` read:
  - `q = {busy, ovr, 6'b0} | cs`, with `cs` zero-extended into bits [CS_COUNT-1:0].
  - The read clears `ovr` on the trigger edge.
- `PORT_DIV` write: `div <= d`. The value is latched into the engine at transfer start, so a write while busy affects only the next transfer.
- `PORT_DATA` write while idle: starts an exchange with tx = `d`.
- `PORT_DATA` read while idle:
  - `q` = the rx register, i.e. the byte received by the previous exchange.
  - The trigger also starts an exchange with tx = 8'hFF.
- Any `PORT_DATA` trigger while busy: ignored (tx, rx and the transfer are unchanged); sets `ovr`. A read still returns the current rx register.
- Engine states:
  - IDLE → SHIFT on start.
  - SHIFT → IDLE after 16 SCK half-periods.
  - The shift register is MSB first. Both modes sample `miso` on the SCK rising edge and change `mosi` on the falling edge.
- Reset values:
  - `cs` all ones; `ck` = 0 (mode 0); `mosi` = 1.
  - rx = 8'hFF; `div` = DIV_RESET; `ovr` = 0; `busy` = 0; state IDLE.
  - `q` = 8'hFF; `qe` = 0.
- Reset mid-transfer aborts immediately to reset values. No partial byte is retained.

## Timing

- Half-period H = `div`+1 clocks. `div`=0 gives SCK = clock/2.
- Trigger seen at edge T:
  - T+1: `busy`=1, `mosi`=tx[7], `ck` at idle level.
- Mode 0: rising edges at T+1+H, T+1+3H, … (8 rising edges). Falling edges at T+1+2H, T+1+4H, …
- Mode 3: an initial falling edge at T+1+H, then alternating edges. The 8th rising edge is at T+1+16H, so SCK finishes high (idle level).
- Sampling and shifting:
  - `miso` is sampled into the shift register at each rising edge.
  - `mosi` advances to the next bit at each falling edge that precedes a further rising edge.
- Completion: `busy`=0 and rx updated at T+1+16H. Total busy time = 16H clocks.
- `mosi` returns to 1 when idle.
- `ck` holds its idle level when idle; a mode change while idle updates the idle level the next cycle.

## Structure

- Package `spi_host_pkg`:
  - state enum (IDLE, SHIFT).
  - status bit positions (BUSY=7, OVR=6).
  - MODE bit position (7).
  - constant MAX_CS=6.
- Sub-module `spi_shift`: divider counter, half-period counter (0..15), 8-bit shift register, SCK/MOSI generation.
- `spi_host` top: bus decode, edge detect, control/divider/status registers, read mux.

## Test plan

- Reset: all outputs at reset values; status read returns 8'h03 with CS_COUNT=2.
- Mode 0, div=0, write 8'hA5 to `PORT_DATA`, `miso` driven with 8'h3C:
  - `mosi` carries 10100101 on rising edges.
  - `busy` is high for 16 clocks.
  - The next `PORT_DATA` read returns 8'h3C and emits 8'hFF on `mosi`.
- Mode 3 (ctrl write 8'h80), div=3:
  - SCK idles high.
  - Exactly 8 rising edges with period 8 clocks.
  - Transfer lasts 64 clocks and SCK ends high.
- Overrun: second `PORT_DATA` write mid-transfer:
  - The transfer is unchanged.
  - Status reads 8'hC0|cs while busy.
  - `ovr` clears after that read.
- A single `PORT_DATA` write held active for 6 clocks triggers exactly one transfer.
- Async reset asserted mid-transfer:
  - `ck`, `mosi`, `cs` return to reset values within the same cycle.
  - rx is 8'hFF afterwards.

Source files
------------

// File: rtl/spi_host_pkg.sv
// Shared constants, state encoding and status helper for the spi_host block.
package spi_host_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int STAT_BUSY = 7;
  localparam int STAT_OVR  = 6;
  localparam int CTRL_MODE = 7;
  localparam int MAX_CS    = 6;

  localparam logic [3:0] HALF_LAST = 4'd15;

  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic ovr,
                                             input logic [MAX_CS-1:0] cs_bits);
    logic [7:0] s;
    s = '0;
    s[MAX_CS-1:0] = cs_bits;
    s[STAT_BUSY]  = busy;
    s[STAT_OVR]   = ovr;
    return s;
  endfunction

endpackage

// File: rtl/spi_host_if.sv
// Z80 decoded I/O port bus as seen by a peripheral.
interface spi_host_if;
  // Strobes are active-low and level based: an access lasts as long as iorq and
  // rd or wr stay low; the peripheral acts once per access and drives q/qe
  // combinationally for as long as a read of one of its readable ports is decoded.
  logic       iorq;
  logic       rd;
  logic       wr;
  logic [7:0] a;
  logic [7:0] d;
  logic [7:0] q;
  logic       qe;

  modport master (output iorq, rd, wr, a, d, input q, qe);
  modport slave  (input iorq, rd, wr, a, d, output q, qe);
endinterface

// File: rtl/spi_shift.sv
// SPI byte engine: SCK divider, 16 half-period sequencer, MSB-first shift register.
module spi_shift
  import spi_host_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] div,
  input  logic       mode,
  input  logic       miso,
  output logic       busy,
  output logic [7:0] rx,
  output logic       ck,
  output logic       mosi,
  output logic [0:0] state_dbg
);

  logic [0:0] state;
  logic [7:0] div_l;
  logic [7:0] div_cnt;
  logic [3:0] half;
  logic       mode_l;
  logic [7:0] sr;
  logic       edge_now;
  logic       rise;
  logic       fall_adv;
  logic [7:0] sr_next;

  // Half index parity decides the edge direction: mode 0 starts with a rising
  // edge, mode 3 with a falling one.  mosi only advances between two samples.
  always_comb begin
    edge_now = (state == ST_SHIFT) && (div_cnt == 8'd0);
    rise     = edge_now && (half[0] == mode_l);
    fall_adv = edge_now && !rise && (half != 4'd0) && (half != HALF_LAST);
    sr_next  = rise ? {sr[6:0], miso} : sr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      div_l   <= '0;
      div_cnt <= '0;
      half    <= '0;
      mode_l  <= 1'b0;
      sr      <= 8'hFF;
      rx      <= 8'hFF;
      ck      <= 1'b0;
      mosi    <= 1'b1;
    end else if (state == ST_IDLE) begin
      ck   <= mode;
      mosi <= 1'b1;
      if (start) begin
        state   <= ST_SHIFT;
        div_l   <= div;
        div_cnt <= div;
        half    <= '0;
        mode_l  <= mode;
        sr      <= tx;
        mosi    <= tx[7];
      end
    end else begin
      if (edge_now) begin
        ck      <= ~ck;
        div_cnt <= div_l;
        half    <= half + 4'd1;
        sr      <= sr_next;
        if (fall_adv) begin
          mosi <= sr[7];
        end
        if (half == HALF_LAST) begin
          state <= ST_IDLE;
          rx    <= sr_next;
          mosi  <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt - 8'd1;
      end
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign state_dbg = state;

endmodule

// File: rtl/spi_host.sv
// SPI host on the Z80 I/O port bus: decode, control/divider/status registers, read mux.
module spi_host
  import spi_host_pkg::*;
#(
  parameter int         CS_COUNT  = 2,
  parameter logic [7:0] PORT_CTRL = 8'h1F,
  parameter logic [7:0] PORT_DATA = 8'h3F,
  parameter logic [7:0] PORT_DIV  = 8'h5F,
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic                clock,
  input  logic                reset,
  spi_host_if.slave           bus,
  output logic [CS_COUNT-1:0] cs,
  output logic                ck,
  output logic                mosi,
  input  logic                miso,
  output state_e              dbg_state
);

  localparam int P_CTRL = 0;
  localparam int P_DATA = 1;
  localparam int P_DIV  = 2;

  logic                strobe;
  logic [2:0]          acc;
  logic [2:0]          acc_q;
  logic [2:0]          acc_p;
  logic [2:0]          trig;
  logic                rd_q;
  logic [7:0]          d_q;
  logic [CS_COUNT-1:0] cs_r;
  logic                mode;
  logic [7:0]          div;
  logic                ovr;
  logic                busy;
  logic                start;
  logic [7:0]          tx;
  logic [7:0]          rx;
  logic [0:0]          eng_state;
  logic [MAX_CS-1:0]   cs_pad;
  logic                qe_c;
  logic [7:0]          q_c;

  always_comb begin
    strobe       = !bus.iorq && (!bus.rd || !bus.wr);
    acc[P_CTRL]  = strobe && (bus.a == PORT_CTRL);
    acc[P_DATA]  = strobe && (bus.a == PORT_DATA);
    acc[P_DIV]   = strobe && (bus.a == PORT_DIV);
  end

  // The access is registered first; acting on its rising edge makes a long
  // I/O cycle fire exactly once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      acc_p <= '0;
      rd_q  <= 1'b0;
      d_q   <= '0;
    end else begin
      acc_q <= acc;
      acc_p <= acc_q;
      rd_q  <= !bus.rd;
      d_q   <= bus.d;
    end
  end

  assign trig  = acc_q & ~acc_p;
  assign start = trig[P_DATA] && !busy;
  assign tx    = rd_q ? 8'hFF : d_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs_r <= '1;
      mode <= 1'b0;
      div  <= DIV_RESET;
      ovr  <= 1'b0;
    end else begin
      if (trig[P_CTRL] && !rd_q) begin
        cs_r <= d_q[CS_COUNT-1:0];
        mode <= d_q[CTRL_MODE];
      end
      if (trig[P_DIV] && !rd_q) begin
        div <= d_q;
      end
      if (trig[P_DATA] && busy) begin
        ovr <= 1'b1;
      end else if (trig[P_CTRL] && rd_q) begin
        ovr <= 1'b0;
      end
    end
  end

  spi_shift u_shift (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .tx        (tx),
    .div       (div),
    .mode      (mode),
    .miso      (miso),
    .busy      (busy),
    .rx        (rx),
    .ck        (ck),
    .mosi      (mosi),
    .state_dbg (eng_state)
  );

  always_comb begin
    cs_pad                = '0;
    cs_pad[CS_COUNT-1:0]  = cs_r;
    qe_c = !bus.iorq && !bus.rd && ((bus.a == PORT_CTRL) || (bus.a == PORT_DATA));
    q_c  = 8'hFF;
    if (qe_c) begin
      q_c = (bus.a == PORT_CTRL) ? status_byte(busy, ovr, cs_pad) : rx;
    end
  end

  assign bus.q     = q_c;
  assign bus.qe    = qe_c;
  assign cs        = cs_r;
  assign dbg_state = state_e'(eng_state);

endmodule

// File: tb/tb_spi_host.sv
// Directed, table-driven bench for spi_host: decode table, transfer table, corner sequences.
module tb_spi_host;
  import spi_host_pkg::*;

  localparam logic [7:0] P_CTRL  = 8'h1F;
  localparam logic [7:0] P_DATA  = 8'h3F;
  localparam logic [7:0] P_DIV   = 8'h5F;

  logic       clock;
  logic       reset;
  logic [1:0] cs;
  logic       ck;
  logic       mosi;
  logic       miso;
  state_e     dbg_state;

  int checks   = 0;
  int failures = 0;

  spi_host_if bus ();

  spi_host #(
    .CS_COUNT  (2),
    .PORT_CTRL (P_CTRL),
    .PORT_DATA (P_DATA),
    .PORT_DIV  (P_DIV),
    .DIV_RESET (8'd3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .cs        (cs),
    .ck        (ck),
    .mosi      (mosi),
    .miso      (miso),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: one bus access held for 'hold' clocks, q sampled on the first negedge.
  task automatic bus_access(input logic [7:0] port, input logic is_rd, input logic [7:0] data,
                            input int hold, output logic [7:0] rdata);
    @(posedge clock);
    #1;
    bus.a    = port;
    bus.d    = data;
    bus.iorq = 1'b0;
    bus.rd   = !is_rd;
    bus.wr   = is_rd;
    @(negedge clock);
    rdata = bus.q;
    repeat (hold) @(posedge clock);
    #1;
    bus.iorq = 1'b1;
    bus.rd   = 1'b1;
    bus.wr   = 1'b1;
  endtask

  // Slave model + monitor for one transfer: drives miso MSB first, collects
  // mosi as seen on each SCK rise, times busy and the rise spacing.
  task automatic watch_xfer(input string tag, input logic [7:0] miso_byte,
                            input logic [7:0] exp_mosi, input int exp_busy,
                            input logic exp_idle_ck);
    int         busy_cnt, rises, bad_per, last_rise, cyc, exp_period;
    logic       seen, done, prev_ck, prev_mosi;
    logic [7:0] got;
    busy_cnt = 0; rises = 0; bad_per = 0; last_rise = -1; cyc = 0;
    seen = 1'b0; done = 1'b0; got = '0;
    exp_period = exp_busy / 8;
    miso      = miso_byte[7];
    prev_ck   = ck;
    prev_mosi = mosi;
    while (!done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (ck && !prev_ck) begin
        got = {got[6:0], prev_mosi};
        if (last_rise >= 0 && (cyc - last_rise) != exp_period) bad_per++;
        last_rise = cyc;
        rises++;
        if (rises < 8) miso = miso_byte[7-rises];
      end
      if (dbg_state == SHIFT) begin
        busy_cnt++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
      prev_ck   = ck;
      prev_mosi = mosi;
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " mosi bits"}, 32'(got), 32'(exp_mosi));
    chk({tag, " busy clocks"}, busy_cnt, exp_busy);
    chk({tag, " sck rises"}, rises, 8);
    chk({tag, " sck period errors"}, bad_per, 0);
    chk({tag, " sck end level"}, 32'(ck), 32'(exp_idle_ck));
    chk({tag, " mosi idle"}, 32'(mosi), 32'd1);
  endtask

  typedef struct {
    string      name;
    logic       iorq;
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] exp_q;
    logic       exp_qe;
  } dec_vec_t;

  typedef struct {
    string      name;
    logic       mode;
    logic [7:0] div;
    logic [1:0] csv;
    logic [7:0] tx;
    logic [7:0] miso_b;
    int         exp_busy;
  } xfer_vec_t;

  dec_vec_t   dv[7];
  xfer_vec_t  xv[4];
  logic [7:0] r1;
  logic [7:0] r2;
  int         extra_busy;
  int         waited;

  initial begin
    dv[0] = '{"dec idle",        1'b1, 1'b0, 1'b1, P_CTRL, 8'hFF, 1'b0};
    dv[1] = '{"dec ctrl read",   1'b0, 1'b0, 1'b1, P_CTRL, 8'h03, 1'b1};
    dv[2] = '{"dec data read",   1'b0, 1'b0, 1'b1, P_DATA, 8'hFF, 1'b1};
    dv[3] = '{"dec div read",    1'b0, 1'b0, 1'b1, P_DIV,  8'hFF, 1'b0};
    dv[4] = '{"dec ctrl write",  1'b0, 1'b1, 1'b0, P_CTRL, 8'hFF, 1'b0};
    dv[5] = '{"dec other port",  1'b0, 1'b0, 1'b1, 8'h20,  8'hFF, 1'b0};
    dv[6] = '{"dec no iorq",     1'b1, 1'b0, 1'b1, P_DATA, 8'hFF, 1'b0};

    xv[0] = '{"m0 div0", 1'b0, 8'd0, 2'b10, 8'hA5, 8'h3C, 16};
    xv[1] = '{"m3 div3", 1'b1, 8'd3, 2'b01, 8'h5A, 8'hC3, 64};
    xv[2] = '{"m0 div1", 1'b0, 8'd1, 2'b00, 8'h81, 8'h7E, 32};
    xv[3] = '{"m3 div0", 1'b1, 8'd0, 2'b11, 8'h00, 8'hFF, 16};

    bus.iorq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.a = 8'h00; bus.d = 8'h00;
    miso  = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Reset state
    @(negedge clock);
    chk("reset ck", 32'(ck), 32'd0);
    chk("reset mosi", 32'(mosi), 32'd1);
    chk("reset cs", 32'(cs), 32'h3);
    chk("reset state", 32'(dbg_state), 32'(IDLE));

    // Combinational decode table; no clock edge falls inside a vector.
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #2;
      bus.iorq = dv[i].iorq; bus.rd = dv[i].rd; bus.wr = dv[i].wr; bus.a = dv[i].a;
      #2;
      chk({dv[i].name, " q"}, 32'(bus.q), 32'(dv[i].exp_q));
      chk({dv[i].name, " qe"}, 32'(bus.qe), 32'(dv[i].exp_qe));
      bus.iorq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
    end

    // Transfer table: configure, write, then read back with an 8'hFF exchange.
    for (int i = 0; i < 4; i++) begin
      bus_access(P_CTRL, 1'b0, {xv[i].mode, 5'b0, xv[i].csv}, 1, r1);
      bus_access(P_DIV, 1'b0, xv[i].div, 1, r1);
      bus_access(P_CTRL, 1'b1, 8'h00, 1, r1);
      chk({xv[i].name, " status"}, 32'(r1), 32'({6'b0, xv[i].csv}));
      chk({xv[i].name, " cs pins"}, 32'(cs), 32'(xv[i].csv));
      chk({xv[i].name, " sck idle"}, 32'(ck), 32'(xv[i].mode));
      fork
        bus_access(P_DATA, 1'b0, xv[i].tx, 1, r1);
        watch_xfer({xv[i].name, " write"}, xv[i].miso_b, xv[i].tx, xv[i].exp_busy, xv[i].mode);
      join
      fork
        bus_access(P_DATA, 1'b1, 8'h00, 1, r2);
        watch_xfer({xv[i].name, " read"}, 8'h00, 8'hFF, xv[i].exp_busy, xv[i].mode);
      join
      chk({xv[i].name, " rx readback"}, 32'(r2), 32'(xv[i].miso_b));
    end

    // Overrun: second data write and a divider write while busy.
    bus_access(P_CTRL, 1'b0, 8'h01, 1, r1);
    bus_access(P_DIV, 1'b0, 8'd3, 1, r1);
    fork
      begin
        bus_access(P_DATA, 1'b0, 8'h96, 1, r1);
        repeat (10) @(posedge clock);
        bus_access(P_DATA, 1'b0, 8'h00, 1, r1);
        bus_access(P_DIV, 1'b0, 8'd0, 1, r1);
        bus_access(P_CTRL, 1'b1, 8'h00, 1, r1);
        chk("ovr status busy", 32'(r1), 32'hC1);
        bus_access(P_CTRL, 1'b1, 8'h00, 1, r1);
        chk("ovr cleared busy", 32'(r1), 32'h81);
      end
      watch_xfer("ovr xfer", 8'h69, 8'h96, 64, 1'b0);
    join
    bus_access(P_CTRL, 1'b1, 8'h00, 1, r1);
    chk("ovr status idle", 32'(r1), 32'h01);
    fork
      bus_access(P_DATA, 1'b1, 8'h00, 1, r2);
      watch_xfer("new div xfer", 8'h5A, 8'hFF, 16, 1'b0);
    join
    chk("ovr rx", 32'(r2), 32'h69);

    // A data write held for 6 clocks must start exactly one transfer.
    bus_access(P_CTRL, 1'b0, 8'h02, 1, r1);
    fork
      bus_access(P_DATA, 1'b0, 8'h3C, 6, r1);
      watch_xfer("held write", 8'hA5, 8'h3C, 16, 1'b0);
    join
    extra_busy = 0;
    repeat (40) begin
      @(negedge clock);
      if (dbg_state == SHIFT) extra_busy++;
    end
    chk("held write retrigger", extra_busy, 0);
    bus_access(P_CTRL, 1'b1, 8'h00, 1, r1);
    chk("held write no ovr", 32'(r1), 32'h02);

    // Asynchronous reset in the middle of a transfer with SCK high and mosi low.
    bus_access(P_CTRL, 1'b0, 8'h00, 1, r1);
    bus_access(P_DIV, 1'b0, 8'd3, 1, r1);
    miso = 1'b1;
    bus_access(P_DATA, 1'b0, 8'h00, 1, r1);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!(ck && dbg_state == SHIFT) && waited < 200);
    chk("mid-xfer sck high reached", 32'(ck), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset ck", 32'(ck), 32'd0);
    chk("async reset mosi", 32'(mosi), 32'd1);
    chk("async reset cs", 32'(cs), 32'h3);
    chk("async reset state", 32'(dbg_state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b1;
    bus_access(P_CTRL, 1'b1, 8'h00, 1, r1);
    chk("post reset status", 32'(r1), 32'h03);
    fork
      bus_access(P_DATA, 1'b1, 8'h00, 1, r2);
      watch_xfer("post reset xfer", 8'hC3, 8'hFF, 64, 1'b0);
    join
    chk("post reset rx", 32'(r2), 32'hFF);
    fork
      bus_access(P_DATA, 1'b1, 8'h00, 1, r2);
      watch_xfer("final xfer", 8'h00, 8'hFF, 64, 1'b0);
    join
    chk("final rx", 32'(r2), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
